// File: rtl/ifetch_responder_if.sv
// Fetch-request and byte-wide RAM bus bundle shared by the fetch responder and its environment.
interface ifetch_responder_if;
  logic        req_e;
  logic [31:0] req_pc;
  logic        flush;
  logic [7:0]  mem_din;
  logic        mem_gnt;
  logic        mem_req;
  logic [31:0] mem_a;
  logic [1:0]  ok;
  logic [31:0] dt;
  logic        cache_hit;

  modport master (
    output req_e, req_pc, flush, mem_din, mem_gnt,
    input  mem_req, mem_a, ok, dt, cache_hit
  );

  modport slave (
    input  req_e, req_pc, flush, mem_din, mem_gnt,
    output mem_req, mem_a, ok, dt, cache_hit
  );
endinterface

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: direct-mapped one-word-per-line cache in front of an 8-bit RAM bus.
// On a miss the top byte is never registered; it reaches the fetch stage live on the RAM data lines.
module ifetch_responder #(
  parameter int unsigned IDX_W = 6
) (
  input logic              clk,
  input logic              rst,
  ifetch_responder_if.slave bus
);
  localparam int unsigned LINES = 1 << IDX_W;
  localparam int unsigned LA_W  = 30;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DELIVER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ok_q, ok_d;
  logic [31:0]       dt_q, dt_d;
  logic              cache_hit_q, cache_hit_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_a_q, mem_a_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [LA_W-1:0]   pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [1:0]        pend_idx_q, pend_idx_d;
  logic [2:0][7:0]   byte_q, byte_d;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [IDX_W-1:0]  req_idx_c, fill_idx_c;
  logic [TAG_W-1:0]  req_tag_c, fill_tag_c;
  logic              hit_c, lookup_c, fire_c, last_c, fill_we_c;
  logic [1:0]        ok_next_c;
  logic [2:0][7:0]   byte_c;
  logic              unused_c;

  assign req_idx_c  = bus.req_pc[IDX_W+1:2];
  assign req_tag_c  = bus.req_pc[31:IDX_W+2];
  assign fill_idx_c = pc_q[IDX_W-1:0];
  assign fill_tag_c = pc_q[LA_W-1:IDX_W];
  assign unused_c   = ^bus.req_pc[1:0];

  assign hit_c     = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);
  assign lookup_c  = (state_q == S_IDLE) && bus.req_e && !bus.flush;
  // A grant coinciding with a flush is not an issued byte.
  assign fire_c    = (state_q == S_FETCH) && mem_req_q && bus.mem_gnt && !bus.flush;
  assign last_c    = fire_c && (cnt_q == 2'd3);
  assign fill_we_c = (state_q == S_DELIVER) && !bus.flush;
  assign ok_next_c = (ok_q == 2'd3) ? 2'd1 : ok_q + 2'd1;

  // Byte buffer with this cycle's returning RAM byte merged in.
  always_comb begin
    byte_c = byte_q;
    if (pend_q) begin
      case (pend_idx_q)
        2'd0:    byte_c[0] = bus.mem_din;
        2'd1:    byte_c[1] = bus.mem_din;
        2'd2:    byte_c[2] = bus.mem_din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (lookup_c && !hit_c) state_d = S_FETCH;
      S_FETCH:   if (last_c)             state_d = S_DELIVER;
      S_DELIVER:                         state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_comb begin
    ok_d        = ok_q;
    dt_d        = dt_q;
    cache_hit_d = cache_hit_q;
    mem_req_d   = mem_req_q;
    mem_a_d     = mem_a_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    pend_d      = 1'b0;
    pend_idx_d  = pend_idx_q;
    byte_d      = byte_c;
    case (state_q)
      S_IDLE: begin
        if (lookup_c) begin
          if (hit_c) begin
            ok_d        = ok_next_c;
            dt_d        = data_q[req_idx_c];
            cache_hit_d = 1'b1;
          end else begin
            pc_d      = bus.req_pc[31:2];
            mem_a_d   = {bus.req_pc[31:2], 2'b00};
            mem_req_d = 1'b1;
            cnt_d     = 2'd0;
          end
        end
      end
      S_FETCH: begin
        if (fire_c) begin
          mem_a_d = mem_a_q + 32'd1;
          cnt_d   = cnt_q + 2'd1;
          if (last_c) begin
            // Deliver on entry to DELIVER so ok changes while byte 3 is live.
            mem_req_d   = 1'b0;
            ok_d        = ok_next_c;
            dt_d        = {8'h00, byte_c[2], byte_c[1], byte_c[0]};
            cache_hit_d = 1'b0;
          end else begin
            pend_d     = 1'b1;
            pend_idx_d = cnt_q;
          end
        end
      end
      default: ;
    endcase
    if (bus.flush) begin
      mem_req_d = 1'b0;
      cnt_d     = 2'd0;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ok_q        <= 2'd0;
      dt_q        <= 32'd0;
      cache_hit_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_a_q     <= 32'd0;
      cnt_q       <= 2'd0;
      pc_q        <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= 2'd0;
      byte_q      <= '0;
    end else begin
      ok_q        <= ok_d;
      dt_q        <= dt_d;
      cache_hit_q <= cache_hit_d;
      mem_req_q   <= mem_req_d;
      mem_a_q     <= mem_a_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      byte_q      <= byte_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           valid_q             <= '0;
    else if (fill_we_c) valid_q[fill_idx_c] <= 1'b1;
  end

  // Line fill takes the top byte straight off the RAM bus during DELIVER.
  always_ff @(posedge clk) begin
    if (fill_we_c) begin
      tag_q[fill_idx_c]  <= fill_tag_c;
      data_q[fill_idx_c] <= {bus.mem_din, byte_c[2], byte_c[1], byte_c[0]};
    end
  end

  assign bus.ok        = ok_q;
  assign bus.dt        = dt_q;
  assign bus.cache_hit = cache_hit_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_a     = mem_a_q;
endmodule

// File: tb/tb_ifetch_responder.sv
// Self-checking bench for ifetch_responder against a transaction-level cache/RAM model.
module tb_ifetch_responder;
  logic clk = 1'b0;
  logic rst;

  ifetch_responder_if bus();

  ifetch_responder #(.IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ram [logic [31:0]];
  logic [31:0] salt;
  bit          mv    [64];
  logic [31:0] mline [64];
  logic [31:0] mdata [64];
  int          ok_m;
  int          last_lat;

  function automatic logic [7:0] rb(input logic [31:0] a);
    logic [31:0] h;
    if (ram.exists(a)) return ram[a];
    h = (a * 32'h9E3779B1) ^ salt;
    return h[31:24];
  endfunction

  function automatic int ok_after(input int o);
    return (o == 3) ? 1 : o + 1;
  endfunction

  function automatic void model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    ok_m = 0;
  endfunction

  // RAM: a granted address returns its byte on the next cycle, otherwise junk.
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_gnt) bus.mem_din <= rb(bus.mem_a);
    else                            bus.mem_din <= 8'($urandom);
  end

  task automatic run_fetch(input logic [31:0] pc, input int gmode, input bit flush_dl);
    logic [31:0] base, exp_a, exp_dt;
    int idx, edges, stalls, issued, stall_left, nok;
    bit g, hit;
    base = {pc[31:2], 2'b00};
    idx  = int'(base[7:2]);
    hit  = mv[idx] && (mline[idx] == base);
    nok  = ok_after(ok_m);
    @(negedge clk);
    bus.req_e = 1'b1; bus.req_pc = pc; bus.flush = 1'b0;
    @(posedge clk); #1;
    bus.req_e = 1'b0;
    if (hit) begin
      n_cmp++; if (bus.ok !== 2'(nok)) begin n_err++; $display("FAIL hit_ok pc=%h: got %0d expected %0d", pc, bus.ok, nok); end
      n_cmp++; if (bus.dt !== mdata[idx]) begin n_err++; $display("FAIL hit_dt pc=%h: got %h expected %h", pc, bus.dt, mdata[idx]); end
      n_cmp++; if (bus.cache_hit !== 1'b1) begin n_err++; $display("FAIL hit_flag pc=%h: got %b expected 1", pc, bus.cache_hit); end
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL hit_memreq pc=%h: got %b expected 0", pc, bus.mem_req); end
      ok_m = nok; last_lat = 1;
      return;
    end
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL miss_req pc=%h: got %b expected 1", pc, bus.mem_req); end
    n_cmp++; if (bus.mem_a !== base) begin n_err++; $display("FAIL miss_addr0 pc=%h: got %h expected %h", pc, bus.mem_a, base); end
    n_cmp++; if (bus.ok !== 2'(ok_m)) begin n_err++; $display("FAIL miss_ok_hold pc=%h: got %0d expected %0d", pc, bus.ok, ok_m); end
    exp_a = base; edges = 0; stalls = 0; issued = 0; stall_left = 2;
    while (edges < 200) begin
      @(negedge clk);
      case (gmode)
        0:       g = 1'b1;
        1:       g = ($urandom_range(0, 2) != 0);
        default: begin
          g = !((exp_a == base + 32'd1) && (stall_left > 0));
          if (!g) stall_left--;
        end
      endcase
      if (issued >= 4) g = 1'b1;
      bus.mem_gnt = g;
      if (issued < 4) begin
        if (g) begin issued++; exp_a = exp_a + 32'd1; end
        else stalls++;
      end
      @(posedge clk); #1;
      edges++;
      if (bus.ok !== 2'(ok_m)) break;
      n_cmp++; if (bus.mem_a !== exp_a) begin n_err++; $display("FAIL fetch_addr pc=%h: got %h expected %h", pc, bus.mem_a, exp_a); end
      n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_req pc=%h: got %b expected 1", pc, bus.mem_req); end
    end
    exp_dt = {8'h00, rb(base + 32'd2), rb(base + 32'd1), rb(base)};
    n_cmp++; if (edges != 4 + stalls) begin n_err++; $display("FAIL miss_latency pc=%h: got %0d expected %0d", pc, edges, 4 + stalls); end
    n_cmp++; if (bus.ok !== 2'(nok)) begin n_err++; $display("FAIL miss_ok pc=%h: got %0d expected %0d", pc, bus.ok, nok); end
    n_cmp++; if (bus.dt !== exp_dt) begin n_err++; $display("FAIL miss_dt pc=%h: got %h expected %h", pc, bus.dt, exp_dt); end
    n_cmp++; if (bus.cache_hit !== 1'b0) begin n_err++; $display("FAIL miss_flag pc=%h: got %b expected 0", pc, bus.cache_hit); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL miss_req_drop pc=%h: got %b expected 0", pc, bus.mem_req); end
    ok_m = nok; last_lat = edges;
    @(negedge clk);
    bus.flush = flush_dl; bus.mem_gnt = 1'($urandom);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (!flush_dl) begin
      mv[idx] = 1'b1; mline[idx] = base;
      mdata[idx] = {rb(base + 32'd3), rb(base + 32'd2), rb(base + 32'd1), rb(base)};
    end
    n_cmp++; if (bus.ok !== 2'(ok_m)) begin n_err++; $display("FAIL post_deliver_ok pc=%h: got %0d expected %0d", pc, bus.ok, ok_m); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.ok, bus.dt, bus.cache_hit, bus.mem_req, bus.mem_a} !== 68'd0) begin
      n_err++; $display("FAIL reset_outputs: got ok=%0d dt=%h hit=%b req=%b a=%h expected all 0", bus.ok, bus.dt, bus.cache_hit, bus.mem_req, bus.mem_a);
    end
  endtask

  task automatic test_cold_miss();
    run_fetch(32'h0000_0000, 0, 1'b0);
    n_cmp++; if (bus.dt !== 32'h0010_0513) begin n_err++; $display("FAIL cold_dt: got %h expected 00100513", bus.dt); end
    n_cmp++; if (bus.ok !== 2'd1) begin n_err++; $display("FAIL cold_ok: got %0d expected 1", bus.ok); end
    n_cmp++; if (last_lat != 4) begin n_err++; $display("FAIL cold_latency: got %0d expected 4", last_lat); end
  endtask

  task automatic test_warm_hit();
    run_fetch(32'h0000_0002, 0, 1'b0);
    n_cmp++; if (bus.dt !== 32'h0010_0513) begin n_err++; $display("FAIL warm_dt: got %h expected 00100513", bus.dt); end
    n_cmp++; if (bus.ok !== 2'd2) begin n_err++; $display("FAIL warm_ok: got %0d expected 2", bus.ok); end
  endtask

  task automatic test_flush_idle_hit();
    @(negedge clk);
    bus.req_e = 1'b1; bus.req_pc = 32'h0; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_e = 1'b0; bus.flush = 1'b0;
    n_cmp++; if (bus.ok !== 2'(ok_m)) begin n_err++; $display("FAIL flush_hit_ok: got %0d expected %0d", bus.ok, ok_m); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL flush_hit_req: got %b expected 0", bus.mem_req); end
  endtask

  task automatic test_grant_stall();
    run_fetch(32'h0000_0104, 2, 1'b0);
    n_cmp++; if (last_lat != 6) begin n_err++; $display("FAIL stall_latency: got %0d expected 6", last_lat); end
    run_fetch(32'h0000_0104, 0, 1'b0);
  endtask

  task automatic test_flush_mid_fetch();
    @(negedge clk);
    bus.req_e = 1'b1; bus.req_pc = 32'h40; bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.req_e = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL flush_req: got %b expected 0", bus.mem_req); end
    n_cmp++; if (bus.ok !== 2'(ok_m)) begin n_err++; $display("FAIL flush_ok: got %0d expected %0d", bus.ok, ok_m); end
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (bus.ok !== 2'(ok_m)) begin n_err++; $display("FAIL flush_ok_later: got %0d expected %0d", bus.ok, ok_m); end
    run_fetch(32'h40, 0, 1'b0);
    n_cmp++; if (last_lat != 4) begin n_err++; $display("FAIL flush_refetch_miss: got latency %0d expected 4", last_lat); end
  endtask

  task automatic test_flush_deliver();
    run_fetch(32'h0000_02C0, 1, 1'b1);
    run_fetch(32'h0000_02C0, 0, 1'b0);
    n_cmp++; if (last_lat != 4) begin n_err++; $display("FAIL flush_dl_nofill: got latency %0d expected 4", last_lat); end
  endtask

  task automatic test_conflict();
    int ok_start;
    ok_start = ok_m;
    run_fetch(32'h0000_0100, 0, 1'b0);
    run_fetch(32'h0000_0000, 0, 1'b0);
    n_cmp++; if (last_lat != 4) begin n_err++; $display("FAIL conflict_evict: got latency %0d expected 4", last_lat); end
    run_fetch(32'h0000_0000, 0, 1'b0);
    n_cmp++; if (bus.ok !== 2'(ok_start)) begin n_err++; $display("FAIL ok_wrap: got %0d expected %0d", bus.ok, ok_start); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.req_e = 1'b1; bus.req_pc = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ok_m = ok_after(ok_m);
      n_cmp++; if (bus.ok !== 2'(ok_m)) begin n_err++; $display("FAIL b2b_ok[%0d]: got %0d expected %0d", i, bus.ok, ok_m); end
      n_cmp++; if (bus.cache_hit !== 1'b1) begin n_err++; $display("FAIL b2b_flag[%0d]: got %b expected 1", i, bus.cache_hit); end
      n_cmp++; if (bus.dt !== mdata[0]) begin n_err++; $display("FAIL b2b_dt[%0d]: got %h expected %h", i, bus.dt, mdata[0]); end
    end
    bus.req_e = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.req_e = 1'b1; bus.req_pc = 32'h208; bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.req_e = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ok, bus.dt, bus.cache_hit, bus.mem_req, bus.mem_a} !== 68'd0) begin
      n_err++; $display("FAIL async_reset: got ok=%0d dt=%h hit=%b req=%b a=%h expected all 0", bus.ok, bus.dt, bus.cache_hit, bus.mem_req, bus.mem_a);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_fetch(32'h0000_0000, 0, 1'b0);
    n_cmp++; if (last_lat != 4) begin n_err++; $display("FAIL reset_invalidate: got latency %0d expected 4", last_lat); end
    run_fetch(32'h208, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] base;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) base = 32'hFFFF_FFFC;
      else base = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2);
      run_fetch(base | 32'($urandom_range(0, 3)), int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    salt = $urandom;
    ram[32'h0] = 8'h13; ram[32'h1] = 8'h05; ram[32'h2] = 8'h10; ram[32'h3] = 8'h00;
    rst = 1'b0;
    bus.req_e = 1'b0; bus.req_pc = 32'h0; bus.flush = 1'b0; bus.mem_gnt = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_flush_idle_hit();
    test_grant_stall();
    test_flush_mid_fetch();
    test_flush_deliver();
    test_conflict();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifetch_responder.md
# ifetch_responder

Memory-side responder for the instruction-fetch stage. It takes a word-aligned fetch address, serves it from a direct-mapped one-word-per-line instruction cache, or fetches it byte-by-byte over the 8-bit RAM bus on a miss. It signals each delivered word with a 2-bit change-coded `ok` strobe plus `dt`/`cache_hit`. On a miss, the top byte is not registered: it is the live RAM byte, which reaches the fetch stage directly as `rom_rn`.

## Interface
- `IDX_W`, 6: cache index width; 2^IDX_W lines.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_e`  in  1  fetch request valid; level, sampled in IDLE.
- `req_pc`  in  32  fetch address; bits [1:0] ignored (treated as 0).
- `flush`  in  1  abandon current fetch (control-flow redirect).
- `mem_din`  in  8  RAM read byte; valid the cycle after a granted address. Also wired externally to the fetch stage as `rom_rn`.
- `mem_gnt`  in  1  RAM arbiter grant for the current `mem_a`.
- `mem_req`  out  1  RAM read request.
- `mem_a`  out  32  RAM byte address.
- `ok`  out  2  delivery code; a change of value marks a new word.
- `dt`  out  32  delivered word (hit) or {8'h00, byte2, byte1, byte0} (miss).
- `cache_hit`  out  1  1 = `dt` is the full word; 0 = upper byte is on `rom_rn` this cycle.

## Operation
- **Reset values:** `ok`=0, `dt`=0, `cache_hit`=0, `mem_req`=0, `mem_a`=0. State = IDLE. All valid bits are 0.
- **Address split:**
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
- **`ok` sequence:** 1→2→3→1…, advancing by one per delivery. It is held between deliveries and is 0 only after reset.
- **State IDLE:** with `req_e`=1 and `flush`=0, do a combinational lookup.
  - Hit (valid and tag match): at the edge, `ok` advances, `dt`←line, `cache_hit`←1. Stay in IDLE, so back-to-back hits are serviced every cycle.
  - Miss: at the edge, latch pc, `mem_a`←pc, `mem_req`←1, byte counter←0. Go to FETCH.
- **State FETCH:** a byte is issued in a cycle where `mem_req`=1 and `mem_gnt`=1.
  - When a byte is issued, `mem_a` advances by 1 and the counter increments.
  - When no byte is issued, `mem_a` is held.
  - The data for an issued byte is captured from `mem_din` in the following cycle into byte0..byte2.
  - `mem_req` drops after byte 3 is issued. Go to DELIVER.
- **State DELIVER:** one cycle; byte 3 is on `mem_din`.
  - The edge *entering* DELIVER sets `ok` to advance, `dt`←{0, b2, b1, b0} and `cache_hit`←0. This makes `ok` change in the same cycle that byte 3 is live.
  - During DELIVER the line is written: {`mem_din`, b2, b1, b0}, with the tag, valid=1.
  - Return to IDLE.
- **`dt`/`cache_hit`** hold their values until the next delivery.
- **Flush:**
  - In any state, `flush`=1 forces IDLE at the next edge.
  - `mem_req`←0 and the byte counter is cleared.
  - No cache write, and no further `ok` change for the abandoned fetch.
  - A grant in the flush cycle is ignored.
- **Flush during DELIVER:** the `ok`/`dt` change has already happened. The line write is suppressed (the byte may belong to a redirected stream).
- **Flush in IDLE with a hit:** no delivery.
- **Reset mid-fetch:** returns everything to the reset values immediately; the cache is invalidated.

## Timing
- **Hit latency:** request in cycle n → new `ok` and `dt` visible in cycle n+1.
- **Miss latency with continuous grant:**
  - Request in cycle n.
  - `mem_a` = pc, pc+1, pc+2, pc+3 in cycles n+1..n+4.
  - Bytes arrive in cycles n+2..n+5.
  - `ok` changes in cycle n+5, with byte 3 on `mem_din`/`rom_rn`.
- Each cycle of `mem_gnt`=0 while `mem_req`=1 adds one cycle.
- **Address arithmetic:** 32-bit wrap at 0xFFFFFFFC+3.

## Test plan
- **Cold miss.** Reset, then `req_pc`=0x00000000 with RAM bytes 13 05 10 00 and constant grant.
  - Required: `mem_a` = 0, 1, 2, 3 in cycles 1–4.
  - `ok` goes 0→1 in cycle 5, with `dt`=0x00100513 (upper byte 0), `cache_hit`=0, `mem_din`=0x00.
- **Warm hit.** Re-request 0x00000000.
  - Required: `ok` 1→2 one cycle later, `dt`=0x00100513, `cache_hit`=1, `mem_req` stays 0.
- **Grant stall.** Miss at 0x00000104 with `mem_gnt` low for 2 cycles while `mem_a`=0x105.
  - Required: `mem_a` holds at 0x105.
  - Delivery occurs 2 cycles later than without the stall.
  - Captured bytes are correct.
- **Flush mid-fetch.** Miss at 0x40, then `flush` after 2 bytes are issued.
  - Required: `mem_req` drops and `ok` is unchanged.
  - A later request to 0x40 misses again, i.e. no fill occurred.
- **Conflict.** Miss on 0x0 fills index 0; a miss on 0x100 (IDX_W=6) evicts it.
  - Required: a request to 0x0 then misses.
  - Check `ok` wrap 3→1 across 3+ deliveries.
- **Async reset.** Assert `rst`=0 during FETCH.
  - Required: all outputs are 0 before the next clock edge.
  - After release, a request to the previous address misses.
